// File: rtl/mmio_uart_tx_if.sv
// CPU-side memory-mapped bus for the UART transmitter.
interface mmio_uart_tx_if;
  logic        memwrite;
  logic [15:0] dataadr;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        sel;

  modport master (
    output memwrite, dataadr, writedata,
    input  readdata, sel
  );

  modport slave (
    input  memwrite, dataadr, writedata,
    output readdata, sel
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: 4-entry byte FIFO feeding an 8N1 serializer.
// TXDATA at BASE_ADDR (store pushes, load returns count), STATUS at BASE_ADDR+2.
module mmio_uart_tx #(
  parameter logic [15:0] BASE_ADDR    = 16'hFF00,
  parameter int          CLKS_PER_BIT = 16
) (
  input  logic         clk,
  input  logic         reset,
  mmio_uart_tx_if.slave bus,
  output logic         tx,
  output logic         busy
);

  localparam logic [15:0] STATUS_ADDR = BASE_ADDR + 16'd2;
  localparam logic [7:0]  BAUD_MAX    = 8'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state_q, state_d;
  logic [7:0]  baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;

  logic [7:0]  fifo_mem [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic        ovf_q, ovf_d;

  logic hit_data, hit_stat, push_req, push_ok, pop, full, empty;

  assign hit_data = (bus.dataadr == BASE_ADDR);
  assign hit_stat = (bus.dataadr == STATUS_ADDR);
  assign full     = (count_q == 3'd4);
  assign empty    = (count_q == 3'd0);
  assign push_req = bus.memwrite && hit_data;
  // Fullness is judged on the registered count, so a same-cycle pop never rescues a push.
  assign push_ok  = push_req && !full;
  assign pop      = (state_q == IDLE) && !empty;

  assign busy = (state_q != IDLE) || !empty;
  assign tx   = tx_q;

  // Register read mux and select, purely decoded from the address.
  always_comb begin
    bus.readdata = 16'h0000;
    bus.sel      = hit_data || hit_stat;
    if (hit_data)
      bus.readdata = {13'b0, count_q};
    else if (hit_stat)
      bus.readdata = {12'b0, empty, ovf_q, full, busy};
  end

  // FIFO pointer, count and sticky overflow next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + {2'b0, push_ok} - {2'b0, pop};
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 2'd1;
    if (pop)     rd_ptr_d = rd_ptr_q + 2'd1;
    // A dropped push in the same cycle as a clear leaves overflow set.
    if (push_req && full)
      ovf_d = 1'b1;
    else if (bus.memwrite && hit_stat && bus.writedata[2])
      ovf_d = 1'b0;
  end

  // FIFO control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; contents need no reset since count gates validity.
  always_ff @(posedge clk) begin
    if (!reset && push_ok)
      fifo_mem[wr_ptr_q] <= bus.writedata[7:0];
  end

  // Serializer next-state: one baud counter shared by every bit period.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          shift_d = fifo_mem[rd_ptr_q];
          state_d = START;
          tx_d    = 1'b0;
          baud_d  = 8'd0;
          bit_d   = 3'd0;
        end
      end
      START: begin
        if (baud_q == BAUD_MAX) begin
          baud_d  = 8'd0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      DATA: begin
        if (baud_q == BAUD_MAX) begin
          baud_d = 8'd0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      STOP: begin
        if (baud_q == BAUD_MAX) begin
          baud_d  = 8'd0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Serializer registers; tx is driven only from here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= 8'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx with CLKS_PER_BIT=4.
module tb_mmio_uart_tx;
  localparam int CPB = 4;
  localparam logic [15:0] BASE = 16'hFF00;
  localparam logic [15:0] STAT = 16'hFF02;

  logic clk;
  logic reset;
  logic tx;
  logic busy;
  int   checks;
  int   failures;

  mmio_uart_tx_if bus_if ();

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .tx    (tx),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [15:0] addr, input logic [15:0] data);
    bus_if.memwrite  = 1'b1;
    bus_if.dataadr   = addr;
    bus_if.writedata = data;
    tick();
    bus_if.memwrite  = 1'b0;
    bus_if.dataadr   = 16'h0000;
    bus_if.writedata = 16'h0000;
  endtask

  task automatic read_chk(input string tag, input logic [15:0] addr,
                          input logic [15:0] exp_data, input logic exp_sel);
    bus_if.dataadr = addr;
    #1;
    chk(tag, bus_if.readdata, exp_data);
    chk({tag, "_sel"}, {15'b0, bus_if.sel}, {15'b0, exp_sel});
    bus_if.dataadr = 16'h0000;
  endtask

  // Line level expected i cycles after the start edge of an 8N1 frame.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    int k;
    k = i / CPB;
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  // Checks the rest of a frame from cycle 'start'; leaves time just after the frame's last edge.
  task automatic check_frame(input logic [7:0] b, input int start);
    int bad;
    bad = 0;
    for (int i = start; i < 10 * CPB; i++) begin
      if (tx !== frame_bit(b, i)) begin
        if (bad == 0)
          chk($sformatf("frame_%02h_cycle%0d", b, i), {15'b0, tx}, {15'b0, frame_bit(b, i)});
        bad++;
      end
      tick();
    end
    if (bad == 0) chk($sformatf("frame_%02h", b), 16'd0, 16'd0 + 16'(bad));
  endtask

  task automatic check_silent(input string tag, input int cycles);
    int lows;
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      if (tx !== 1'b1) lows++;
      tick();
    end
    chk(tag, 16'(lows), 16'd0);
  endtask

  logic [7:0] q[$];
  logic [7:0] b;
  logic [7:0] first;
  int k;

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus_if.memwrite = 1'b0;
    bus_if.dataadr = 16'h0000;
    bus_if.writedata = 16'h0000;

    // Reset state
    repeat (3) tick();
    chk("rst_tx", {15'b0, tx}, 16'd1);
    chk("rst_busy", {15'b0, busy}, 16'd0);
    read_chk("rst_status", STAT, 16'h0008, 1'b1);
    reset = 1'b0;
    tick();
    read_chk("rst_count", BASE, 16'h0000, 1'b1);

    // Single frame 0xA5, upper byte ignored
    store(BASE, 16'h3CA5);
    chk("a5_busy_e0", {15'b0, busy}, 16'd1);
    chk("a5_tx_e0", {15'b0, tx}, 16'd1);
    tick();
    check_frame(8'hA5, 0);
    chk("a5_busy_end", {15'b0, busy}, 16'd0);
    chk("a5_tx_end", {15'b0, tx}, 16'd1);

    // Back-to-back 0x11, 0x22 with one idle cycle
    store(BASE, 16'h0011);
    store(BASE, 16'h0022);
    check_frame(8'h11, 0);
    chk("gap_11_22", {15'b0, tx}, 16'd1);
    tick();
    check_frame(8'h22, 0);
    chk("b2b_busy_end", {15'b0, busy}, 16'd0);

    // Randomized bursts against a byte-queue model
    repeat (4) begin
      k = $urandom_range(1, 4);
      q = {};
      for (int j = 0; j < k; j++) begin
        b = 8'($urandom_range(0, 255));
        q.push_back(b);
        store(BASE, {8'($urandom_range(0, 255)), b});
      end
      if (k == 1) begin
        tick();
        check_frame(q.pop_front(), 0);
      end else begin
        check_frame(q.pop_front(), k - 2);
      end
      while (q.size() > 0) begin
        chk("rand_gap", {15'b0, tx}, 16'd1);
        tick();
        check_frame(q.pop_front(), 0);
      end
      chk("rand_busy_end", {15'b0, busy}, 16'd0);
    end
    read_chk("rand_status", STAT, 16'h0008, 1'b1);

    // Overflow: 5 pushes during a frame, fifth dropped, then cleared
    first = 8'($urandom_range(0, 255));
    store(BASE, {8'h00, first});
    tick();
    q = {};
    for (int j = 0; j < 5; j++) begin
      b = 8'($urandom_range(0, 255));
      if (j < 4) q.push_back(b);
      store(BASE, {8'h00, b});
    end
    read_chk("ovf_status", STAT, 16'h0007, 1'b1);
    read_chk("ovf_count", BASE, 16'h0004, 1'b1);
    store(STAT, 16'h0004);
    read_chk("ovf_cleared", STAT, 16'h0003, 1'b1);
    check_frame(first, 6);
    while (q.size() > 0) begin
      chk("ovf_gap", {15'b0, tx}, 16'd1);
      tick();
      check_frame(q.pop_front(), 0);
    end
    check_silent("ovf_dropped_not_sent", 50);
    read_chk("ovf_final_status", STAT, 16'h0008, 1'b1);

    // Address decode, unmapped store, then reset during DATA bit 3
    store(BASE, 16'h00C3);
    tick();
    store(BASE, 16'h0055);
    store(BASE, 16'h0066);
    read_chk("count_two", BASE, 16'h0002, 1'b1);
    read_chk("unmapped_read", 16'h0040, 16'h0000, 1'b0);
    store(16'h0040, 16'h0077);
    read_chk("unmapped_store", BASE, 16'h0002, 1'b1);
    repeat (14) tick();
    chk("bit3_level", {15'b0, tx}, {15'b0, frame_bit(8'hC3, 17)});
    reset = 1'b1;
    bus_if.memwrite = 1'b1;
    bus_if.dataadr = BASE;
    bus_if.writedata = 16'h0099;
    tick();
    bus_if.memwrite = 1'b0;
    bus_if.dataadr = 16'h0000;
    chk("abort_tx", {15'b0, tx}, 16'd1);
    chk("abort_busy", {15'b0, busy}, 16'd0);
    read_chk("abort_status", STAT, 16'h0008, 1'b1);
    reset = 1'b0;
    check_silent("abort_no_frame", 60);
    read_chk("abort_final_status", STAT, 16'h0008, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'hFF00, byte address of the TXDATA register; STATUS sits at BASE_ADDR+2.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range 2..255.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 memwrite  input  1  CPU store strobe, one cycle per store.
REQ-006 dataadr  input  16  CPU byte address.
REQ-007 writedata  input  16  CPU store data.
REQ-008 readdata  output  16  register read data, combinational from dataadr.
REQ-009 sel  output  1  combinational; 1 when dataadr equals BASE_ADDR or BASE_ADDR+2; used by the system read mux.
REQ-010 tx  output  1  serial line, idle high.
REQ-011 busy  output  1  1 when the FSM is not IDLE or the FIFO is non-empty.

Function
REQ-012 Store to BASE_ADDR (memwrite=1) SHALL push writedata[7:0] into a 4-entry FIFO; writedata[15:8] ignored.
REQ-013 Push when the registered count is 4 SHALL be dropped and SHALL set sticky overflow, even if a pop happens in the same cycle.
REQ-014 Push and pop in the same cycle with count 1..3 SHALL leave count unchanged and preserve data order.
REQ-015 Store to BASE_ADDR+2 SHALL clear overflow when writedata[2]=1; other bits ignored.
REQ-016 Read at BASE_ADDR+2 SHALL return {12'b0, count==0, overflow, count==4, busy}, i.e. bit0 busy, bit1 full, bit2 overflow, bit3 empty.
REQ-017 Read at BASE_ADDR SHALL return {13'b0, count[2:0]}; any unmapped address SHALL return 16'h0000 with sel=0.
REQ-018 Stores to unmapped addresses SHALL have no effect.
REQ-019 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-020 IDLE with FIFO non-empty: at the next edge, pop the head into the shift register, enter START, drive tx=0, clear the bit counter.
REQ-021 START: hold tx=0 for CLKS_PER_BIT cycles, then enter DATA with tx=bit0.
REQ-022 DATA: send 8 bits LSB first, each held CLKS_PER_BIT cycles; after bit7, enter STOP with tx=1.
REQ-023 STOP: hold tx=1 for CLKS_PER_BIT cycles, then return to IDLE.
REQ-024 tx SHALL be registered, with no combinational path from bus inputs.
REQ-025 Frame SHALL be exactly 10*CLKS_PER_BIT cycles; back-to-back frames SHALL be separated by exactly 1 idle cycle, the IDLE pop cycle.
REQ-026 Latency: push at edge E0 into an empty FIFO in IDLE -> tx falls after edge E1.
REQ-027 Baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 on each bit boundary.
REQ-028 Bus activity during a frame SHALL NOT disturb the frame in progress.

Reset
REQ-029 While reset=1 at an edge, all of the following SHALL hold: state=IDLE, tx=1, FIFO count=0, pointers=0, overflow=0, baud and bit counters=0, busy=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame: tx=1 after that edge and queued bytes discarded.
REQ-031 Reset SHALL take priority over a simultaneous store.

Verification
REQ-032 CLKS_PER_BIT=4, store 16'h00A5 to 16'hFF00 -> tx low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles; busy falls after cycle 40.
REQ-033 Stores 0x11,0x22 on consecutive cycles -> two frames in order with exactly 1 idle-high cycle between them.
REQ-034 While the first frame transmits, push 5 more bytes -> 5th dropped, read 16'hFF02 = 16'h0007, i.e. busy, full and overflow set; store 16'h0004 to 16'hFF02 -> overflow clears.
REQ-035 Reads: 16'hFF00 with 2 queued -> 16'h0002, sel=1; 16'h0040 -> 16'h0000, sel=0; store to 16'h0040 -> no push.
REQ-036 Assert reset during DATA bit 3 -> tx=1 next cycle, STATUS=16'h0008, and no further frame is sent.
